// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap controller.
//   - exception / interrupt cause codes
//   - mstatus bit positions touched on trap entry and MRET
//   - privilege-level encodings
//   - trap sequencer state encoding
package trap_controller_pkg;

  // Synchronous exception cause codes
  localparam logic [3:0] CAUSE_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LD_MISALIGN    = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN    = 4'd6;
  // ECALL from U is 8, from M is 11: the code is CAUSE_ECALL_U + priv_lvl.
  localparam logic [3:0] CAUSE_ECALL_U        = 4'd8;

  // Interrupt cause codes, also the bit positions in mip/mie
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // mstatus bit indices
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Trap sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTER = 3'd1,
    ST_TVEC  = 3'd2,
    ST_RET   = 3'd3,
    ST_RETPC = 3'd4
  } state_t;

endpackage

// File: rtl/trap_controller_prio_enc.sv
// Combinational trap priority encoder.
// Picks the single winning event among masked interrupts, synchronous
// exceptions and MRET for the committing instruction.
// Ports:
//   instr_valid            commit qualifier; nothing wins without it
//   pc_addr, instr_bits    committing PC / instruction word (tval sources)
//   exc_*, csr_exc_*       exception sources
//   ebreak, ecall, mret    system instruction flags
//   mem_addr               load/store effective address (tval source)
//   irq_pend               mip & mie
//   irq_eligible           global interrupt enable for the current privilege
//   priv_lvl               current privilege
//   valid                  an event wins this cycle
//   is_irq                 winner is an interrupt
//   code                   cause code of the winner
//   tval                   mtval value of the winner
//   is_mret                winner is a legal MRET (no trap)
module trap_controller_prio_enc
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     instr_bits,
  input  logic            exc_fetch_misalign,
  input  logic            exc_illegal,
  input  logic            csr_exc_en,
  input  logic [3:0]      csr_exc_code,
  input  logic [XLEN-1:0] csr_exc_val,
  input  logic            ebreak,
  input  logic            ecall,
  input  logic            exc_ld_misalign,
  input  logic            exc_st_misalign,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mret,
  input  logic [XLEN-1:0] irq_pend,
  input  logic            irq_eligible,
  input  logic [1:0]      priv_lvl,
  output logic            valid,
  output logic            is_irq,
  output logic [3:0]      code,
  output logic [XLEN-1:0] tval,
  output logic            is_mret
);

  logic            illegal;
  logic [XLEN-1:0] instr_tval;
  logic            unused_irq_bits;

  // MRET below M-mode is itself an illegal instruction.
  assign illegal    = exc_illegal | (mret & (priv_lvl != PRIV_M));
  assign instr_tval = {{(XLEN-32){1'b0}}, instr_bits};

  // Only MSI, MTI and MEI are implemented.
  assign unused_irq_bits = ^{irq_pend[XLEN-1:12], irq_pend[10:8], irq_pend[6:4], irq_pend[2:0]};

  always_comb begin
    valid   = 1'b0;
    is_irq  = 1'b0;
    code    = 4'd0;
    tval    = '0;
    is_mret = 1'b0;
    if (instr_valid) begin
      valid = 1'b1;
      if (irq_eligible && irq_pend[IRQ_MEI]) begin
        is_irq = 1'b1;
        code   = IRQ_MEI;
      end else if (irq_eligible && irq_pend[IRQ_MSI]) begin
        is_irq = 1'b1;
        code   = IRQ_MSI;
      end else if (irq_eligible && irq_pend[IRQ_MTI]) begin
        is_irq = 1'b1;
        code   = IRQ_MTI;
      end else if (exc_fetch_misalign) begin
        code = CAUSE_FETCH_MISALIGN;
        tval = pc_addr;
      end else if (illegal) begin
        // Takes precedence over a simultaneous CSR fault on purpose.
        code = CAUSE_ILLEGAL;
        tval = instr_tval;
      end else if (csr_exc_en) begin
        code = csr_exc_code;
        tval = csr_exc_val;
      end else if (ebreak) begin
        code = CAUSE_BREAKPOINT;
      end else if (ecall) begin
        code = CAUSE_ECALL_U + {2'b00, priv_lvl};
      end else if (exc_ld_misalign) begin
        code = CAUSE_LD_MISALIGN;
        tval = mem_addr;
      end else if (exc_st_misalign) begin
        code = CAUSE_ST_MISALIGN;
        tval = mem_addr;
      end else if (mret) begin
        is_mret = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer; producer side of the CSR trap interface.
// Owns the privilege register, drives the *_next CSR values with the
// trap_taken / trap_done strobes, and redirects fetch on trap entry and MRET.
// Sequences: IDLE -> ENTER -> TVEC -> IDLE (trap), IDLE -> RET -> RETPC -> IDLE (MRET).
// Handshake: there is no ready/valid pair. A source is consumed only in IDLE
// in a cycle with instr_valid=1; flush kills that instruction in the same
// cycle, and stall holds the pipeline for every non-IDLE cycle so the
// upstream keeps its next instruction until the sequence ends.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   instr_valid..mret          commit-stage sources (see trap_controller_prio_enc)
//   irq_pend                   mip & mie
//   mstatus_current            mstatus from the CSR file
//   mtvec_trap                 mtvec snapshot, used in TVEC
//   mepc_out                   live mepc, used for MRET
//   trap_taken / trap_done     one-cycle CSR latch strobes
//   mepc_next..mstatus_next    values for the CSR file
//   pc_redirect_en/pc_redirect fetch redirect
//   flush, stall               pipeline control
//   priv_lvl                   current privilege
//   fsm_state                  sequencer state for observation
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int         XLEN        = 64,
  parameter logic [1:0] RESET_PRIV  = 2'b11,
  parameter int         VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     instr_bits,
  input  logic            exc_fetch_misalign,
  input  logic            exc_illegal,
  input  logic            csr_exc_en,
  input  logic [3:0]      csr_exc_code,
  input  logic [XLEN-1:0] csr_exc_val,
  input  logic            ebreak,
  input  logic            ecall,
  input  logic            exc_ld_misalign,
  input  logic            exc_st_misalign,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mret,
  input  logic [XLEN-1:0] irq_pend,
  input  logic [XLEN-1:0] mstatus_current,
  input  logic [XLEN-1:0] mtvec_trap,
  input  logic [XLEN-1:0] mepc_out,
  output logic            trap_taken,
  output logic            trap_done,
  output logic [XLEN-1:0] mepc_next,
  output logic [XLEN-1:0] mcause_next,
  output logic [XLEN-1:0] mtval_next,
  output logic [XLEN-1:0] mstatus_next,
  output logic            pc_redirect_en,
  output logic [XLEN-1:0] pc_redirect,
  output logic            flush,
  output logic            stall,
  output logic [1:0]      priv_lvl,
  output logic [2:0]      fsm_state
);

  state_t          state_q, state_d;
  logic [1:0]      priv_q;
  logic [1:0]      ret_priv_q;   // MPP captured at MRET commit
  logic            irq_q;
  logic [3:0]      code_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mstatus_q;

  logic            irq_eligible;
  logic            enc_valid, enc_is_irq, enc_is_mret;
  logic [3:0]      enc_code;
  logic [XLEN-1:0] enc_tval;
  logic [XLEN-1:0] tvec_base;

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms,
                                                      input logic [1:0] priv);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    return r;
  endfunction

  // Interrupts are always enabled below M-mode, gated by MIE in M-mode.
  assign irq_eligible = mstatus_current[MSTATUS_MIE] | (priv_q < PRIV_M);

  trap_controller_prio_enc #(.XLEN(XLEN)) u_prio_enc (
    .instr_valid        (instr_valid),
    .pc_addr            (pc_addr),
    .instr_bits         (instr_bits),
    .exc_fetch_misalign (exc_fetch_misalign),
    .exc_illegal        (exc_illegal),
    .csr_exc_en         (csr_exc_en),
    .csr_exc_code       (csr_exc_code),
    .csr_exc_val        (csr_exc_val),
    .ebreak             (ebreak),
    .ecall              (ecall),
    .exc_ld_misalign    (exc_ld_misalign),
    .exc_st_misalign    (exc_st_misalign),
    .mem_addr           (mem_addr),
    .mret               (mret),
    .irq_pend           (irq_pend),
    .irq_eligible       (irq_eligible),
    .priv_lvl           (priv_q),
    .valid              (enc_valid),
    .is_irq             (enc_is_irq),
    .code               (enc_code),
    .tval               (enc_tval),
    .is_mret            (enc_is_mret)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      priv_q     <= RESET_PRIV;
      ret_priv_q <= PRIV_U;
      irq_q      <= 1'b0;
      code_q     <= 4'd0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mstatus_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (enc_valid && enc_is_mret) begin
            // mcause / mtval deliberately keep their last values.
            mepc_q     <= mepc_out;
            mstatus_q  <= mstatus_on_mret(mstatus_current);
            ret_priv_q <= mstatus_current[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end else if (enc_valid) begin
            mepc_q    <= pc_addr;
            mcause_q  <= {enc_is_irq, {(XLEN-5){1'b0}}, enc_code};
            mtval_q   <= enc_tval;
            mstatus_q <= mstatus_on_trap(mstatus_current, priv_q);
            irq_q     <= enc_is_irq;
            code_q    <= enc_code;
          end
        end
        ST_ENTER: priv_q <= PRIV_M;
        ST_RET:   priv_q <= ret_priv_q;
        default:  ;
      endcase
    end
  end

  // Vectored mode offsets only interrupts, by 4*cause.
  always_comb begin
    tvec_base = {mtvec_trap[XLEN-1:2], 2'b00};
    if ((VECTORED_EN != 0) && irq_q && (mtvec_trap[1:0] == 2'b01))
      tvec_base = tvec_base + {{(XLEN-6){1'b0}}, code_q, 2'b00};
  end

  always_comb begin
    state_d        = state_q;
    flush          = 1'b0;
    stall          = 1'b1;
    trap_taken     = 1'b0;
    trap_done      = 1'b0;
    pc_redirect_en = 1'b0;
    pc_redirect    = '0;
    case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
        if (enc_valid) begin
          flush   = 1'b1;
          state_d = enc_is_mret ? ST_RET : ST_ENTER;
        end
      end
      ST_ENTER: begin
        trap_taken = 1'b1;
        state_d    = ST_TVEC;
      end
      ST_TVEC: begin
        pc_redirect_en = 1'b1;
        pc_redirect    = tvec_base;
        state_d        = ST_IDLE;
      end
      ST_RET: begin
        trap_done = 1'b1;
        state_d   = ST_RETPC;
      end
      ST_RETPC: begin
        pc_redirect_en = 1'b1;
        pc_redirect    = {mepc_out[XLEN-1:2], 2'b00};
        state_d        = ST_IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mepc_next    = mepc_q;
  assign mcause_next  = mcause_q;
  assign mtval_next   = mtval_q;
  assign mstatus_next = mstatus_q;
  assign priv_lvl     = priv_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a table of single-commit events with
// hand-computed CSR values, plus hand-written sequences for back-to-back
// traps and asynchronous reset during trap entry.
module tb_trap_controller;

  localparam int KIND_NONE = 0;
  localparam int KIND_TRAP = 1;
  localparam int KIND_RET  = 2;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [63:0] pc_addr;
  logic [31:0] instr_bits;
  logic        exc_fetch_misalign, exc_illegal, csr_exc_en;
  logic [3:0]  csr_exc_code;
  logic [63:0] csr_exc_val;
  logic        ebreak, ecall, exc_ld_misalign, exc_st_misalign;
  logic [63:0] mem_addr;
  logic        mret;
  logic [63:0] irq_pend, mstatus_current, mtvec_trap, mepc_out;
  logic        trap_taken, trap_done;
  logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next;
  logic        pc_redirect_en;
  logic [63:0] pc_redirect;
  logic        flush, stall;
  logic [1:0]  priv_lvl;
  logic [2:0]  fsm_state;

  trap_controller dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_addr(pc_addr),
    .instr_bits(instr_bits), .exc_fetch_misalign(exc_fetch_misalign),
    .exc_illegal(exc_illegal), .csr_exc_en(csr_exc_en), .csr_exc_code(csr_exc_code),
    .csr_exc_val(csr_exc_val), .ebreak(ebreak), .ecall(ecall),
    .exc_ld_misalign(exc_ld_misalign), .exc_st_misalign(exc_st_misalign),
    .mem_addr(mem_addr), .mret(mret), .irq_pend(irq_pend),
    .mstatus_current(mstatus_current), .mtvec_trap(mtvec_trap), .mepc_out(mepc_out),
    .trap_taken(trap_taken), .trap_done(trap_done), .mepc_next(mepc_next),
    .mcause_next(mcause_next), .mtval_next(mtval_next), .mstatus_next(mstatus_next),
    .pc_redirect_en(pc_redirect_en), .pc_redirect(pc_redirect), .flush(flush),
    .stall(stall), .priv_lvl(priv_lvl), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] ib;
    logic        fetch, ill, csr_en;
    logic [3:0]  csr_code;
    logic [63:0] csr_val;
    logic        ebrk, ecl, ldm, stm;
    logic [63:0] maddr;
    logic        mret;
    logic [63:0] irq, mst, mtvec, mepc;
    int          kind;
    logic [63:0] e_mepc, e_mcause, e_mtval, e_mstatus, e_redir;
    logic [1:0]  e_priv;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] exp_q[$];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t blank();
    vec_t v;
    v.valid = 1'b1; v.pc = 64'h1000; v.ib = 32'h0000_0073;
    v.fetch = 0; v.ill = 0; v.csr_en = 0; v.csr_code = 0; v.csr_val = 0;
    v.ebrk = 0; v.ecl = 0; v.ldm = 0; v.stm = 0; v.maddr = 0; v.mret = 0;
    v.irq = 0; v.mst = 64'h8; v.mtvec = 64'h200; v.mepc = 0;
    v.kind = KIND_TRAP; v.e_mepc = 0; v.e_mcause = 0; v.e_mtval = 0;
    v.e_mstatus = 0; v.e_redir = 0; v.e_priv = 2'd3;
    return v;
  endfunction

  task automatic clear_src();
    instr_valid = 0; exc_fetch_misalign = 0; exc_illegal = 0; csr_exc_en = 0;
    csr_exc_code = 0; csr_exc_val = 0; ebreak = 0; ecall = 0;
    exc_ld_misalign = 0; exc_st_misalign = 0; mem_addr = 0; mret = 0; irq_pend = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    instr_valid = v.valid; pc_addr = v.pc; instr_bits = v.ib;
    exc_fetch_misalign = v.fetch; exc_illegal = v.ill; csr_exc_en = v.csr_en;
    csr_exc_code = v.csr_code; csr_exc_val = v.csr_val; ebreak = v.ebrk;
    ecall = v.ecl; exc_ld_misalign = v.ldm; exc_st_misalign = v.stm;
    mem_addr = v.maddr; mret = v.mret; irq_pend = v.irq;
    mstatus_current = v.mst; mtvec_trap = v.mtvec; mepc_out = v.mepc;
  endtask

  // Drives one commit in IDLE and follows the whole sequence back to IDLE.
  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive_vec(v);
    #1;
    check($sformatf("v%0d flush", idx), {63'd0, flush}, (v.kind != KIND_NONE) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    clear_src();
    @(negedge clk);
    if (v.kind == KIND_NONE) begin
      check($sformatf("v%0d idle stall", idx), {63'd0, stall}, 64'd0);
      check($sformatf("v%0d idle strobes", idx), {62'd0, trap_taken, trap_done}, 64'd0);
    end else begin
      check($sformatf("v%0d trap_taken", idx), {63'd0, trap_taken}, (v.kind == KIND_TRAP) ? 64'd1 : 64'd0);
      check($sformatf("v%0d trap_done", idx), {63'd0, trap_done}, (v.kind == KIND_RET) ? 64'd1 : 64'd0);
      check($sformatf("v%0d stall", idx), {63'd0, stall}, 64'd1);
      check($sformatf("v%0d mepc_next", idx), mepc_next, v.e_mepc);
      check($sformatf("v%0d mcause_next", idx), mcause_next, v.e_mcause);
      check($sformatf("v%0d mtval_next", idx), mtval_next, v.e_mtval);
      check($sformatf("v%0d mstatus_next", idx), mstatus_next, v.e_mstatus);
      @(negedge clk);
      check($sformatf("v%0d redirect_en", idx), {63'd0, pc_redirect_en}, 64'd1);
      check($sformatf("v%0d pc_redirect", idx), pc_redirect, v.e_redir);
      @(negedge clk);
      check($sformatf("v%0d back idle", idx), {61'd0, fsm_state}, 64'd0);
      check($sformatf("v%0d redirect_en low", idx), {63'd0, pc_redirect_en}, 64'd0);
    end
    check($sformatf("v%0d priv_lvl", idx), {62'd0, priv_lvl}, {62'd0, v.e_priv});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    logic [2:0] exp_bits;
    logic [2:0] got_bits;
    int tt_count;

    rst = 0;
    clear_src();
    pc_addr = 0; instr_bits = 0; mstatus_current = 0; mtvec_trap = 0; mepc_out = 0;

    // v0: ecall from M
    v = blank(); v.ecl = 1;
    v.e_mepc = 64'h1000; v.e_mcause = 64'd11; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v1: MTI, vectored mtvec
    v = blank(); v.irq = 64'h80; v.pc = 64'h1100; v.mtvec = 64'h201;
    v.e_mepc = 64'h1100; v.e_mcause = 64'h8000_0000_0000_0007; v.e_mstatus = 64'h1880; v.e_redir = 64'h21C; tbl.push_back(v);
    // v2: illegal + ld_misalign + MEI with MIE=0 in M; exception ignores vectoring
    v = blank(); v.ill = 1; v.ldm = 1; v.maddr = 64'h3001; v.irq = 64'h800; v.mst = 0;
    v.ib = 32'hDEAD_BEEF; v.mtvec = 64'h201; v.pc = 64'h1200;
    v.e_mepc = 64'h1200; v.e_mcause = 64'd2; v.e_mtval = 64'hDEAD_BEEF; v.e_mstatus = 64'h1800; v.e_redir = 64'h200; tbl.push_back(v);
    // v3: load misaligned
    v = blank(); v.ldm = 1; v.maddr = 64'h3001; v.pc = 64'h1300; v.mtvec = 64'h300;
    v.e_mepc = 64'h1300; v.e_mcause = 64'd4; v.e_mtval = 64'h3001; v.e_mstatus = 64'h1880; v.e_redir = 64'h300; tbl.push_back(v);
    // v4: ebreak beats ecall
    v = blank(); v.ebrk = 1; v.ecl = 1; v.pc = 64'h1400;
    v.e_mepc = 64'h1400; v.e_mcause = 64'd3; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v5: CSR fault beats ebreak
    v = blank(); v.csr_en = 1; v.csr_code = 4'd5; v.csr_val = 64'h1234; v.ebrk = 1; v.pc = 64'h1500;
    v.e_mepc = 64'h1500; v.e_mcause = 64'd5; v.e_mtval = 64'h1234; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v6: illegal + CSR fault -> cause 2, tval = instruction
    v = blank(); v.ill = 1; v.csr_en = 1; v.csr_code = 4'd5; v.csr_val = 64'h1234; v.ib = 32'h1234_5678; v.pc = 64'h1600;
    v.e_mepc = 64'h1600; v.e_mcause = 64'd2; v.e_mtval = 64'h1234_5678; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v7: fetch misaligned beats illegal, tval = pc
    v = blank(); v.fetch = 1; v.ill = 1; v.pc = 64'h1702;
    v.e_mepc = 64'h1702; v.e_mcause = 64'd0; v.e_mtval = 64'h1702; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v8: store misaligned
    v = blank(); v.stm = 1; v.maddr = 64'h4002; v.pc = 64'h1800;
    v.e_mepc = 64'h1800; v.e_mcause = 64'd6; v.e_mtval = 64'h4002; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v9: MSI beats MTI, vectored
    v = blank(); v.irq = 64'h88; v.mtvec = 64'h201; v.pc = 64'h1900;
    v.e_mepc = 64'h1900; v.e_mcause = 64'h8000_0000_0000_0003; v.e_mstatus = 64'h1880; v.e_redir = 64'h20C; tbl.push_back(v);
    // v10: MEI beats MSI and ecall, direct mtvec
    v = blank(); v.irq = 64'h808; v.ecl = 1; v.pc = 64'h1A00;
    v.e_mepc = 64'h1A00; v.e_mcause = 64'h8000_0000_0000_000B; v.e_mstatus = 64'h1880; v.e_redir = 64'h200; tbl.push_back(v);
    // v11: no instr_valid -> nothing
    v = blank(); v.valid = 0; v.ecl = 1; v.kind = KIND_NONE; tbl.push_back(v);
    // v12: MRET from M, MPP=U; mcause/mtval hold v10 values
    v = blank(); v.mret = 1; v.mst = 64'h80; v.mepc = 64'h2003; v.kind = KIND_RET;
    v.e_mepc = 64'h2003; v.e_mcause = 64'h8000_0000_0000_000B; v.e_mtval = 0; v.e_mstatus = 64'h88;
    v.e_redir = 64'h2000; v.e_priv = 2'd0; tbl.push_back(v);
    // v13: MRET from U -> illegal trap, MPP=U
    v = blank(); v.mret = 1; v.mst = 64'h1808; v.ib = 32'h3020_0073; v.pc = 64'h2000;
    v.e_mepc = 64'h2000; v.e_mcause = 64'd2; v.e_mtval = 64'h3020_0073; v.e_mstatus = 64'h80; v.e_redir = 64'h200; tbl.push_back(v);
    // v14: MRET back to U; holds v13 cause/tval
    v = blank(); v.mret = 1; v.mst = 64'h80; v.mepc = 64'h3000; v.kind = KIND_RET;
    v.e_mepc = 64'h3000; v.e_mcause = 64'd2; v.e_mtval = 64'h3020_0073; v.e_mstatus = 64'h88;
    v.e_redir = 64'h3000; v.e_priv = 2'd0; tbl.push_back(v);
    // v15: MSI taken in U although MIE=0
    v = blank(); v.irq = 64'h8; v.mst = 0; v.pc = 64'h3000;
    v.e_mepc = 64'h3000; v.e_mcause = 64'h8000_0000_0000_0003; v.e_mstatus = 64'h0; v.e_redir = 64'h200; tbl.push_back(v);
    // v16: MRET to U with MPIE=0
    v = blank(); v.mret = 1; v.mst = 64'h0; v.mepc = 64'h4000; v.kind = KIND_RET;
    v.e_mepc = 64'h4000; v.e_mcause = 64'h8000_0000_0000_0003; v.e_mtval = 0; v.e_mstatus = 64'h80;
    v.e_redir = 64'h4000; v.e_priv = 2'd0; tbl.push_back(v);
    // v17: ecall from U -> cause 8
    v = blank(); v.ecl = 1; v.mst = 0; v.pc = 64'h4000;
    v.e_mepc = 64'h4000; v.e_mcause = 64'd8; v.e_mstatus = 64'h0; v.e_redir = 64'h200; tbl.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {61'd0, fsm_state}, 64'd0);
    check("reset priv", {62'd0, priv_lvl}, 64'd3);
    check("reset strobes", {60'd0, trap_taken, trap_done, pc_redirect_en, stall}, 64'd0);
    check("reset mcause", mcause_next, 64'd0);
    check("reset mstatus", mstatus_next, 64'd0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < tbl.size(); i++) apply_vec(i, tbl[i]);

    // Back-to-back: ecall held for six cycles yields two full trap sequences.
    // Expected per cycle: {flush, trap_taken, pc_redirect_en}.
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    @(negedge clk);
    v = blank(); v.ecl = 1; v.pc = 64'h5000;
    drive_vec(v);
    tt_count = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      got_bits = {flush, trap_taken, pc_redirect_en};
      exp_bits = exp_q.pop_front();
      check($sformatf("b2b cycle%0d", c), {61'd0, got_bits}, {61'd0, exp_bits});
      if (trap_taken) tt_count++;
      @(negedge clk);
    end
    clear_src();
    check("b2b pulse count", tt_count, 64'd2);

    // Async reset during ENTER: drop to U first so the priv reset is visible.
    v = blank(); v.mret = 1; v.mst = 64'h80; v.mepc = 64'h6000; v.kind = KIND_RET;
    v.e_mepc = 64'h6000; v.e_mcause = 64'd11; v.e_mtval = 0; v.e_mstatus = 64'h88;
    v.e_redir = 64'h6000; v.e_priv = 2'd0;
    apply_vec(100, v);
    @(negedge clk);
    v = blank(); v.ecl = 1; v.pc = 64'h7000;
    drive_vec(v);
    @(posedge clk); #1;
    clear_src();
    check("rst seq enter", {63'd0, trap_taken}, 64'd1);
    #2;
    rst = 0;
    #1;
    check("rst seq state", {61'd0, fsm_state}, 64'd0);
    check("rst seq priv", {62'd0, priv_lvl}, 64'd3);
    check("rst seq trap_taken", {63'd0, trap_taken}, 64'd0);
    check("rst seq redirect_en", {63'd0, pc_redirect_en}, 64'd0);
    @(negedge clk);
    rst = 1;
    tt_count = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pc_redirect_en || trap_taken) tt_count++;
    end
    check("rst seq no pulse", tt_count, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
